css_mcu0_el2_dccm_sram_sink: RTL and testbench
==============================================

CSS_MCU0_EL2_DCCM_SRAM_SINK -- requirements
Module: css_mcu0_el2_dccm_sram_sink

Interface
REQ-001 Parameter NUM_BANKS, default 4: number of independent single-port DCCM banks.
REQ-002 Parameter ADDR_W, default 10: per-bank word index width; bank depth is 2**ADDR_W words.
REQ-003 Parameter DATA_W, default 32: data bits per word.
REQ-004 Parameter ECC_W, default 7: ECC bits per word, stored alongside data.
REQ-005 clk  input  1  the block's one clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-high.
REQ-007 dccm_clken  input  NUM_BANKS  per-bank access enable.
REQ-008 dccm_wren_bank  input  NUM_BANKS  per-bank write select; 1=write, 0=read, qualified by dccm_clken.
REQ-009 dccm_addr_bank  input  NUM_BANKS*ADDR_W  per-bank word index, packed with bank 0 in the LSBs.
REQ-010 dccm_wr_data_bank  input  NUM_BANKS*DATA_W  per-bank write data.
REQ-011 dccm_wr_ecc_bank  input  NUM_BANKS*ECC_W  per-bank write ECC.
REQ-012 dccm_bank_dout  output  NUM_BANKS*DATA_W  per-bank registered read data.
REQ-013 dccm_bank_ecc  output  NUM_BANKS*ECC_W  per-bank registered read ECC.
REQ-014 dccm_rd_vld  output  NUM_BANKS  per-bank pulse; high in the cycle dout/ecc carry a fresh read result.
REQ-015 errinj_sb  input  1  single-bit error injection arm request, 1-cycle pulse.
REQ-016 errinj_db  input  1  double-bit error injection arm request, 1-cycle pulse.
REQ-017 errinj_bank  input  $clog2(NUM_BANKS)  target bank for an arm request.

Function
REQ-018 Write: clken=1 and wren=1 in cycle N shall store {ecc,data} at addr of that bank at the edge ending cycle N; outputs unchanged.
REQ-019 Read: clken=1 and wren=0 in cycle N shall drive the stored word on dout/ecc and assert rd_vld in cycle N+1; latency is exactly 1 cycle.
REQ-020 clken=0: no array access; dout/ecc hold their last value; rd_vld=0.
REQ-021 Write in cycle N followed by a read of the same address in cycle N+1 shall return the cycle-N data.
REQ-022 Banks are fully independent; simultaneous accesses to all banks in one cycle shall all complete with no stall or interaction.
REQ-023 Words never written shall read as X in simulation; the array is not reset.
REQ-024 Per-bank injection FSM with states IDLE, ARM_SB, ARM_DB; reset state IDLE.
REQ-025 errinj_db pulse shall move the bank selected by errinj_bank to ARM_DB from any state.
REQ-026 errinj_sb without errinj_db shall move it to ARM_SB from any state; errinj_db wins when both are pulsed.
REQ-027 When a bank in ARM_SB completes a read, its read result shall have dout bit 0 inverted; in ARM_DB, dout bits 0 and 1 inverted; the FSM then returns to IDLE.
REQ-028 Arm and read of the same bank in the same cycle: that read is uncorrupted; the arm applies to the next read.
REQ-029 Writes shall neither consume nor corrupt an armed injection; stored array contents are never modified by injection.
REQ-030 errinj_bank >= NUM_BANKS shall be ignored.

Reset
REQ-031 While rst=1: dccm_bank_dout=0, dccm_bank_ecc=0, dccm_rd_vld=0, all FSMs IDLE, independent of clk.
REQ-032 An access accepted in the cycle rst asserts shall produce no rd_vld after reset; array contents are preserved across reset.

Configuration
REQ-033 Macro CSS_MCU0_EL2_DCCM_SINK_ERRINJ_EN defined: REQ-024..REQ-030 are implemented.
REQ-034 Macro undefined: errinj_* ports remain present but are ignored; FSM logic is absent; read data is never corrupted.

Verification
REQ-035 Bank 2 write addr 0x3A data 0xDEADBEEF ecc 0x55, next cycle read 0x3A -> cycle after read: dout[2]=0xDEADBEEF, ecc[2]=0x55, rd_vld=4'b0100.
REQ-036 All 4 banks write distinct words at addr 0 in one cycle, then all read in one cycle -> each bank returns its own word; rd_vld=4'hF for exactly 1 cycle.
REQ-037 Read of bank 1, then clken=0 for 3 cycles -> dout[1] holds its value; rd_vld[1]=0 for those cycles.
REQ-038 (ERRINJ_EN) errinj_db with bank 0; write 0x00000000 then read it -> dout[0]=0x00000003; a second read returns 0x00000000.
REQ-039 (ERRINJ_EN) errinj_sb with bank 3 in the same cycle as a bank-3 read of 0x12345678 -> that read returns 0x12345678; the next read returns 0x12345679.
REQ-040 Assert rst during an active read cycle -> outputs go to 0 asynchronously, no rd_vld after release; a read of a previously written address returns the pre-reset data.

Source files
------------

// File: rtl/css_mcu0_el2_dccm_sram_sink_if.sv
// Bus bundle for the DCCM SRAM sink: per-bank access request, read return and
// error-injection arm request. The master side is the core; the slave side is the sink.
interface css_mcu0_el2_dccm_sram_sink_if #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int ECC_W     = 7
);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic [NUM_BANKS-1:0]        dccm_clken;
  logic [NUM_BANKS-1:0]        dccm_wren_bank;
  logic [NUM_BANKS*ADDR_W-1:0] dccm_addr_bank;
  logic [NUM_BANKS*DATA_W-1:0] dccm_wr_data_bank;
  logic [NUM_BANKS*ECC_W-1:0]  dccm_wr_ecc_bank;
  logic [NUM_BANKS*DATA_W-1:0] dccm_bank_dout;
  logic [NUM_BANKS*ECC_W-1:0]  dccm_bank_ecc;
  logic [NUM_BANKS-1:0]        dccm_rd_vld;
  logic                        errinj_sb;
  logic                        errinj_db;
  logic [BANK_W-1:0]           errinj_bank;

  modport master (
    output dccm_clken, dccm_wren_bank, dccm_addr_bank, dccm_wr_data_bank, dccm_wr_ecc_bank,
    output errinj_sb, errinj_db, errinj_bank,
    input  dccm_bank_dout, dccm_bank_ecc, dccm_rd_vld
  );

  modport slave (
    input  dccm_clken, dccm_wren_bank, dccm_addr_bank, dccm_wr_data_bank, dccm_wr_ecc_bank,
    input  errinj_sb, errinj_db, errinj_bank,
    output dccm_bank_dout, dccm_bank_ecc, dccm_rd_vld
  );
endinterface

// File: rtl/css_mcu0_el2_dccm_sram_sink.sv
// Banked single-port DCCM model with 1-cycle registered reads and optional per-bank
// read-data error injection, enabled by defining CSS_MCU0_EL2_DCCM_SINK_ERRINJ_EN.
module css_mcu0_el2_dccm_sram_sink #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int ECC_W     = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  css_mcu0_el2_dccm_sram_sink_if.slave   bus
);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int WORD_W = ECC_W + DATA_W;
  localparam int DEPTH  = 2 ** ADDR_W;

`ifdef CSS_MCU0_EL2_DCCM_SINK_ERRINJ_EN
  typedef enum logic [1:0] {IDLE, ARM_SB, ARM_DB} inj_state_e;
`else
  logic errinj_unused;
  assign errinj_unused = ^{bus.errinj_sb, bus.errinj_db, bus.errinj_bank};
`endif

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] rd_word;
    logic              rd_en;
    logic              wr_en;
    logic [DATA_W-1:0] inj_mask;
    logic [DATA_W-1:0] dout_q;
    logic [ECC_W-1:0]  ecc_q;
    logic              vld_q;

    assign addr    = bus.dccm_addr_bank[gi*ADDR_W +: ADDR_W];
    assign rd_en   = bus.dccm_clken[gi] & ~bus.dccm_wren_bank[gi];
    assign wr_en   = bus.dccm_clken[gi] &  bus.dccm_wren_bank[gi];
    assign rd_word = mem_q[addr];

    // Array is deliberately not reset; writes are blocked only while rst is held.
    always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
        mem_q[addr] <= {bus.dccm_wr_ecc_bank[gi*ECC_W +: ECC_W],
                        bus.dccm_wr_data_bank[gi*DATA_W +: DATA_W]};
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
        ecc_q  <= '0;
        vld_q  <= 1'b0;
      end else begin
        vld_q <= rd_en;
        if (rd_en) begin
          dout_q <= rd_word[DATA_W-1:0] ^ inj_mask;
          ecc_q  <= rd_word[WORD_W-1:DATA_W];
        end
      end
    end

`ifdef CSS_MCU0_EL2_DCCM_SINK_ERRINJ_EN
    inj_state_e state_q, state_d;
    logic       arm_hit;

    // Out-of-range bank numbers never match any genvar index, so they are dropped.
    assign arm_hit = (bus.errinj_sb | bus.errinj_db) && (bus.errinj_bank == BANK_W'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
    end

    // A fresh arm takes priority over a read in the same cycle: the read stays clean.
    always_comb begin
      state_d  = state_q;
      inj_mask = '0;
      if (arm_hit) begin
        state_d = bus.errinj_db ? ARM_DB : ARM_SB;
      end else if (rd_en) begin
        case (state_q)
          ARM_SB:  inj_mask[0]   = 1'b1;
          ARM_DB:  inj_mask[1:0] = 2'b11;
          default: inj_mask      = '0;
        endcase
        state_d = IDLE;
      end
    end
`else
    assign inj_mask = '0;
`endif

    assign bus.dccm_bank_dout[gi*DATA_W +: DATA_W] = dout_q;
    assign bus.dccm_bank_ecc[gi*ECC_W +: ECC_W]    = ecc_q;
    assign bus.dccm_rd_vld[gi]                     = vld_q;
  end
endmodule

// File: tb/tb_css_mcu0_el2_dccm_sram_sink.sv
// Scoreboard bench for the DCCM SRAM sink: reads push expected words per bank, a
// negedge monitor pops and compares on every rd_vld pulse.
module tb_css_mcu0_el2_dccm_sram_sink;
`ifdef CSS_MCU0_EL2_DCCM_SINK_ERRINJ_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  typedef struct {
    logic [31:0] d;
    logic [6:0]  e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[4][$];

  css_mcu0_el2_dccm_sram_sink_if #(.NUM_BANKS(4), .ADDR_W(10), .DATA_W(32), .ECC_W(7)) bus();

  css_mcu0_el2_dccm_sram_sink #(.NUM_BANKS(4), .ADDR_W(10), .DATA_W(32), .ECC_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic set_wr(input int b, input logic [9:0] a, input logic [31:0] d, input logic [6:0] e);
    bus.dccm_clken[b]               = 1'b1;
    bus.dccm_wren_bank[b]           = 1'b1;
    bus.dccm_addr_bank[b*10 +: 10]  = a;
    bus.dccm_wr_data_bank[b*32 +: 32] = d;
    bus.dccm_wr_ecc_bank[b*7 +: 7]  = e;
  endtask

  task automatic set_rd(input int b, input logic [9:0] a, input logic [31:0] d, input logic [6:0] e,
                        input bit expect_it);
    exp_t x;
    bus.dccm_clken[b]              = 1'b1;
    bus.dccm_wren_bank[b]          = 1'b0;
    bus.dccm_addr_bank[b*10 +: 10] = a;
    x.d = d;
    x.e = e;
    if (expect_it) exp_q[b].push_back(x);
  endtask

  task automatic arm(input bit sb, input bit db, input logic [1:0] b);
    bus.errinj_sb   = sb;
    bus.errinj_db   = db;
    bus.errinj_bank = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.dccm_clken     = '0;
    bus.dccm_wren_bank = '0;
    bus.errinj_sb      = 1'b0;
    bus.errinj_db      = 1'b0;
  endtask

  // Monitor: every rd_vld pulse must match the oldest outstanding expectation of its bank.
  initial begin
    forever begin
      @(negedge clk);
      for (int b = 0; b < 4; b++) begin
        if (bus.dccm_rd_vld[b] === 1'b1) begin
          if (exp_q[b].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rd_vld bank %0d: got rd_vld=1 required 0", b);
          end else begin
            exp_t x;
            x = exp_q[b].pop_front();
            chk($sformatf("rd_dout_b%0d", b), bus.dccm_bank_dout[b*32 +: 32], x.d);
            chk($sformatf("rd_ecc_b%0d", b), {25'd0, bus.dccm_bank_ecc[b*7 +: 7]}, {25'd0, x.e});
          end
        end
      end
    end
  end

  initial begin
    bus.dccm_clken        = '0;
    bus.dccm_wren_bank    = '0;
    bus.dccm_addr_bank    = '0;
    bus.dccm_wr_data_bank = '0;
    bus.dccm_wr_ecc_bank  = '0;
    bus.errinj_sb         = 1'b0;
    bus.errinj_db         = 1'b0;
    bus.errinj_bank       = '0;

    // Reset values
    #1 rst = 1'b1;
    #2;
    chk("reset_dout", bus.dccm_bank_dout[31:0] | bus.dccm_bank_dout[63:32] |
                      bus.dccm_bank_dout[95:64] | bus.dccm_bank_dout[127:96], 32'h0);
    chk("reset_ecc", {4'd0, bus.dccm_bank_ecc}, 32'h0);
    chk("reset_vld", {28'd0, bus.dccm_rd_vld}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single-bank write then read-after-write
    set_wr(2, 10'h03A, 32'hDEADBEEF, 7'h55);
    tick();
    set_rd(2, 10'h03A, 32'hDEADBEEF, 7'h55, 1'b1);
    tick();

    // All banks at once
    for (int b = 0; b < 4; b++) set_wr(b, 10'h000, 32'h11110000 + b, 7'(b + 1));
    tick();
    for (int b = 0; b < 4; b++) set_rd(b, 10'h000, 32'h11110000 + b, 7'(b + 1), 1'b1);
    tick();
    tick();

    // Hold with clken low
    set_rd(1, 10'h000, 32'h11110001, 7'h02, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold_dout_b1_c%0d", i), bus.dccm_bank_dout[63:32], 32'h11110001);
      chk($sformatf("hold_vld_b1_c%0d", i), {31'd0, bus.dccm_rd_vld[1]}, 32'h0);
    end

    // Top address boundary and overwrite of bank 3 word 0
    set_wr(0, 10'h3FF, 32'hA5A5A5A5, 7'h7F);
    set_wr(3, 10'h000, 32'h12345678, 7'h2A);
    tick();
    set_rd(0, 10'h3FF, 32'hA5A5A5A5, 7'h7F, 1'b1);
    set_rd(3, 10'h000, 32'h12345678, 7'h2A, 1'b1);
    tick();

    // Double-bit arm on bank 0, a write in between must not consume it
    arm(1'b0, 1'b1, 2'd0);
    tick();
    set_wr(0, 10'h005, 32'h00000000, 7'h00);
    tick();
    set_rd(0, 10'h005, INJ ? 32'h00000003 : 32'h00000000, 7'h00, 1'b1);
    tick();
    set_rd(0, 10'h005, 32'h00000000, 7'h00, 1'b1);
    tick();

    // Single-bit arm coincident with a read of the same bank
    arm(1'b1, 1'b0, 2'd3);
    set_rd(3, 10'h000, 32'h12345678, 7'h2A, 1'b1);
    tick();
    set_rd(3, 10'h000, INJ ? 32'h12345679 : 32'h12345678, 7'h2A, 1'b1);
    tick();
    set_rd(3, 10'h000, 32'h12345678, 7'h2A, 1'b1);
    tick();

    // Both arm pulses: double-bit wins
    arm(1'b1, 1'b1, 2'd1);
    tick();
    set_rd(1, 10'h000, INJ ? 32'h11110002 : 32'h11110001, 7'h02, 1'b1);
    tick();

    // Reset during an active read; a pending arm on bank 2 must be cleared too
    set_wr(2, 10'h010, 32'hCAFEF00D, 7'h11);
    arm(1'b0, 1'b1, 2'd2);
    tick();
    set_rd(2, 10'h03A, 32'hDEADBEEF, 7'h55, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_dout_b2", bus.dccm_bank_dout[95:64], 32'h0);
    chk("async_rst_dout_b3", bus.dccm_bank_dout[127:96], 32'h0);
    chk("async_rst_ecc", {4'd0, bus.dccm_bank_ecc}, 32'h0);
    chk("async_rst_vld", {28'd0, bus.dccm_rd_vld}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    set_rd(2, 10'h010, 32'hCAFEF00D, 7'h11, 1'b1);
    tick();
    set_rd(2, 10'h03A, 32'hDEADBEEF, 7'h55, 1'b1);
    tick();

    tick();
    tick();
    tick();
    for (int b = 0; b < 4; b++) chk($sformatf("pending_reads_b%0d", b), 32'(exp_q[b].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
